// File: rtl/serial_adder16.sv
// Bit-serial N-bit adder: one fulladder1 cell, one bit per clock, LSB first.
// All state lives in dff cells; start/busy/done handshake.

module dff #(
   parameter int              W  = 1,
   parameter logic [W-1:0]    RV = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst) q <= RV;
      else     q <= d;
   end
endmodule

module fulladder1 (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder16 #(
   parameter int N  = 16,
   parameter int CW = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] Sum,
   output logic         Cout,
   output logic         Ofl
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   logic [1:0]    r_state;
   logic [N-1:0]  r_a;
   logic [N-1:0]  r_b;
   logic [N-1:0]  r_ps;
   logic [CW-1:0] r_cnt;
   logic          r_carry;
   logic [N-1:0]  r_sum;
   logic          r_cout;
   logic          r_ofl;

   logic [1:0]    w_state_d;
   logic [N-1:0]  w_a_d;
   logic [N-1:0]  w_b_d;
   logic [N-1:0]  w_ps_d;
   logic [N-1:0]  w_ps_sh;
   logic [CW-1:0] w_cnt_d;
   logic          w_carry_d;
   logic [N-1:0]  w_sum_d;
   logic          w_cout_d;
   logic          w_ofl_d;
   logic          w_s;
   logic          w_co;
   logic          w_idle;
   logic          w_run;
   logic          w_dn;
   logic          w_acc;
   logic          w_last;

   fulladder1 u_fa (
      .a  (r_a[0]),
      .b  (r_b[0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   assign w_idle  = (r_state == S_IDLE);
   assign w_run   = (r_state == S_RUN);
   assign w_dn    = (r_state == S_DONE);
   assign w_acc   = start & (w_idle | w_dn);
   assign w_last  = w_run & (r_cnt == CW'(N - 1));
   assign w_ps_sh = {w_s, r_ps[N-1:1]};

   always_comb begin
      w_state_d = S_IDLE;
      unique case (r_state)
         S_IDLE:  w_state_d = w_acc  ? S_RUN  : S_IDLE;
         S_RUN:   w_state_d = w_last ? S_DONE : S_RUN;
         S_DONE:  w_state_d = w_acc  ? S_RUN  : S_IDLE;
         default: w_state_d = S_IDLE;
      endcase
   end

   always_comb begin
      w_a_d     = r_a;
      w_b_d     = r_b;
      w_carry_d = r_carry;
      w_cnt_d   = r_cnt;
      w_ps_d    = r_ps;
      if (w_acc) begin
         w_a_d     = A;
         w_b_d     = B;
         w_carry_d = Cin;
         w_cnt_d   = '0;
      end else if (w_run) begin
         w_a_d     = r_a >> 1;
         w_b_d     = r_b >> 1;
         w_carry_d = w_co;
         w_ps_d    = w_ps_sh;
         w_cnt_d   = w_last ? '0 : r_cnt + CW'(1);
      end
   end

   // On the last bit r_carry is the carry into the MSB.
   assign w_sum_d  = w_last ? w_ps_sh         : r_sum;
   assign w_cout_d = w_last ? w_co            : r_cout;
   assign w_ofl_d  = w_last ? (r_carry ^ w_co) : r_ofl;

   dff #(.W(2))  u_st  (.clk, .rst, .d(w_state_d), .q(r_state));
   dff #(.W(N))  u_a   (.clk, .rst, .d(w_a_d),     .q(r_a));
   dff #(.W(N))  u_b   (.clk, .rst, .d(w_b_d),     .q(r_b));
   dff #(.W(N))  u_ps  (.clk, .rst, .d(w_ps_d),    .q(r_ps));
   dff #(.W(CW)) u_cnt (.clk, .rst, .d(w_cnt_d),   .q(r_cnt));
   dff #(.W(1))  u_cy  (.clk, .rst, .d(w_carry_d), .q(r_carry));
   dff #(.W(N))  u_sum (.clk, .rst, .d(w_sum_d),   .q(r_sum));
   dff #(.W(1))  u_co  (.clk, .rst, .d(w_cout_d),  .q(r_cout));
   dff #(.W(1))  u_of  (.clk, .rst, .d(w_ofl_d),   .q(r_ofl));

   assign busy = w_run;
   assign done = w_dn;
   assign Sum  = r_sum;
   assign Cout = r_cout;
   assign Ofl  = r_ofl;
endmodule

// File: tb/tb_serial_adder16.sv
// Bench for serial_adder16: directed plan plus random operands,
// checked against plain integer addition.

module tb_serial_adder16;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        Cin;
   logic        busy;
   logic        done;
   logic [15:0] Sum;
   logic        Cout;
   logic        Ofl;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] pub_sum  = 16'h0;

   serial_adder16 #(.N(16), .CW(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .busy  (busy),
      .done  (done),
      .Sum   (Sum),
      .Cout  (Cout),
      .Ofl   (Ofl)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Called at a negedge; returns at the negedge of the done cycle
   // (hold=1) or one cycle after it (hold=0).
   task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                        input logic c, input bit hold, input int inj);
      logic [16:0] tot;
      logic [15:0] es;
      logic        ec;
      logic        eo;
      tot = {1'b0, a} + {1'b0, b} + {16'h0, c};
      es  = tot[15:0];
      ec  = tot[16];
      eo  = (a[15] == b[15]) && (es[15] != a[15]);
      start = 1'b1;
      A = a;
      B = b;
      Cin = c;
      @(negedge clk);
      if (!hold) start = 1'b0;
      A = 16'($urandom);
      B = 16'($urandom);
      Cin = 1'($urandom);
      for (int i = 1; i <= 16; i++) begin
         chk("busy_run", busy, 1);
         chk("done_run", done, 0);
         chk("sum_held", Sum, pub_sum);
         if (inj != 0 && i == inj) begin
            start = 1'b1;
            A = 16'hAAAA;
            B = 16'h5555;
         end else if (!hold) begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 0);
      chk("sum", Sum, es);
      chk("cout", Cout, ec);
      chk("ofl", Ofl, eo);
      pub_sum = es;
      if (!hold) begin
         @(negedge clk);
         chk("done_drop", done, 0);
         chk("busy_idle", busy, 0);
         chk("sum_keep", Sum, es);
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      A = 16'h0;
      B = 16'h0;
      Cin = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", Sum, 0);
      chk("rst_cout", Cout, 0);
      chk("rst_ofl", Ofl, 0);
      rst = 1'b0;
      @(negedge clk);

      do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
      do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
      do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0);
      do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 5);

      start = 1'b1;
      A = 16'h1111;
      B = 16'h2222;
      Cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("busy_pre_abort", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_sum", Sum, 0);
      chk("abort_cout", Cout, 0);
      chk("abort_ofl", Ofl, 0);
      rst = 1'b0;
      pub_sum = 16'h0;
      @(negedge clk);
      do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0);

      do_op(16'h0010, 16'h0020, 1'b0, 1'b1, 0);
      do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 0);
      start = 1'b0;
      @(negedge clk);
      chk("b2b_done_drop", done, 0);
      chk("b2b_idle", busy, 0);

      for (int n = 0; n < 24; n++) begin
         do_op(16'($urandom), 16'($urandom), 1'($urandom),
               1'b0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
